// File: rtl/cva6_store_buffer_model_if.sv
// Bus bundle between the LSU side (master) and the two-stage store buffer (slave).
// Carries the store, commit, memory drain and page-offset match signals.
interface cva6_store_buffer_model_if #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int SPEC_DEPTH   = 4,
    parameter int COMMIT_DEPTH = 8,
    parameter int OFFSET_W     = 12
);
    localparam int BE_W = DATA_W / 8;
    localparam int SCW  = $clog2(SPEC_DEPTH + 1);
    localparam int CCW  = $clog2(COMMIT_DEPTH + 1);

    logic                flush_i;
    logic                store_valid_i;
    logic [ADDR_W-1:0]   store_addr_i;
    logic [DATA_W-1:0]   store_data_i;
    logic [BE_W-1:0]     store_be_i;
    logic                store_ready_o;
    logic                commit_i;
    logic                commit_ready_o;
    logic                mem_req_o;
    logic [ADDR_W-1:0]   mem_addr_o;
    logic [DATA_W-1:0]   mem_data_o;
    logic [BE_W-1:0]     mem_be_o;
    logic                mem_gnt_i;
    logic [OFFSET_W-1:0] page_offset_i;
    logic                page_offset_match_o;
    logic                no_st_pending_o;
    logic                store_buffer_empty_o;
    logic [SCW-1:0]      spec_count_o;
    logic [CCW-1:0]      commit_count_o;

    modport master (
        output flush_i, store_valid_i, store_addr_i, store_data_i, store_be_i,
               commit_i, mem_gnt_i, page_offset_i,
        input  store_ready_o, commit_ready_o, mem_req_o, mem_addr_o, mem_data_o,
               mem_be_o, page_offset_match_o, no_st_pending_o, store_buffer_empty_o,
               spec_count_o, commit_count_o
    );

    modport slave (
        input  flush_i, store_valid_i, store_addr_i, store_data_i, store_be_i,
               commit_i, mem_gnt_i, page_offset_i,
        output store_ready_o, commit_ready_o, mem_req_o, mem_addr_o, mem_data_o,
               mem_be_o, page_offset_match_o, no_st_pending_o, store_buffer_empty_o,
               spec_count_o, commit_count_o
    );
endinterface

// File: rtl/cva6_store_buffer_model.sv
// Two-stage store buffer: speculative queue feeding an in-order commit queue that
// drains to memory under req/gnt; flush drops only speculative stores.
module cva6_store_buffer_model #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int SPEC_DEPTH   = 4,
    parameter int COMMIT_DEPTH = 8,
    parameter int OFFSET_W     = 12
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    cva6_store_buffer_model_if.slave sb
);
    localparam int BE_W = DATA_W / 8;
    localparam int SPW  = $clog2(SPEC_DEPTH);
    localparam int CPW  = $clog2(COMMIT_DEPTH);
    localparam int SCW  = $clog2(SPEC_DEPTH + 1);
    localparam int CCW  = $clog2(COMMIT_DEPTH + 1);

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic [BE_W-1:0]   be;
    } entry_t;

    function automatic logic [SPW-1:0] spec_inc(input logic [SPW-1:0] p);
        return (p == SPW'(SPEC_DEPTH - 1)) ? '0 : p + SPW'(1);
    endfunction

    function automatic logic [CPW-1:0] commit_inc(input logic [CPW-1:0] p);
        return (p == CPW'(COMMIT_DEPTH - 1)) ? '0 : p + CPW'(1);
    endfunction

    entry_t                  spec_mem_q   [SPEC_DEPTH];
    entry_t                  spec_mem_d   [SPEC_DEPTH];
    logic [SPEC_DEPTH-1:0]   spec_vld_q,  spec_vld_d;
    logic [SPW-1:0]          spec_rptr_q, spec_rptr_d;
    logic [SPW-1:0]          spec_wptr_q, spec_wptr_d;
    logic [SCW-1:0]          spec_cnt_q,  spec_cnt_d;

    entry_t                  commit_mem_q [COMMIT_DEPTH];
    entry_t                  commit_mem_d [COMMIT_DEPTH];
    logic [COMMIT_DEPTH-1:0] commit_vld_q,  commit_vld_d;
    logic [CPW-1:0]          commit_rptr_q, commit_rptr_d;
    logic [CPW-1:0]          commit_wptr_q, commit_wptr_d;
    logic [CCW-1:0]          commit_cnt_q,  commit_cnt_d;

    logic   store_ready;
    logic   commit_ready;
    logic   mem_req;
    logic   push;
    logic   commit_fire;
    logic   pop;
    entry_t head;

    // Readiness looks only at registered counts, so a same-cycle commit or grant never frees a slot early.
    assign store_ready  = (spec_cnt_q != SCW'(SPEC_DEPTH));
    assign commit_ready = (spec_cnt_q != '0) && (commit_cnt_q != CCW'(COMMIT_DEPTH));
    assign mem_req      = (commit_cnt_q != '0);
    assign push         = sb.store_valid_i && store_ready && !sb.flush_i;
    assign commit_fire  = sb.commit_i && commit_ready;
    assign pop          = sb.mem_gnt_i && mem_req;

    always_comb begin
        spec_mem_d  = spec_mem_q;
        spec_vld_d  = spec_vld_q;
        spec_rptr_d = spec_rptr_q;
        spec_wptr_d = spec_wptr_q;
        if (push) begin
            spec_mem_d[spec_wptr_q] = '{addr: sb.store_addr_i, data: sb.store_data_i, be: sb.store_be_i};
            spec_vld_d[spec_wptr_q] = 1'b1;
            spec_wptr_d             = spec_inc(spec_wptr_q);
        end
        if (commit_fire) begin
            spec_vld_d[spec_rptr_q] = 1'b0;
            spec_rptr_d             = spec_inc(spec_rptr_q);
        end
        spec_cnt_d = spec_cnt_q + SCW'(push) - SCW'(commit_fire);
        // Flush lands after the commit, so the committed head survives and the rest is dropped.
        if (sb.flush_i) begin
            spec_vld_d  = '0;
            spec_cnt_d  = '0;
            spec_rptr_d = spec_wptr_q;
        end
    end

    always_comb begin
        commit_mem_d  = commit_mem_q;
        commit_vld_d  = commit_vld_q;
        commit_rptr_d = commit_rptr_q;
        commit_wptr_d = commit_wptr_q;
        if (commit_fire) begin
            commit_mem_d[commit_wptr_q] = spec_mem_q[spec_rptr_q];
            commit_vld_d[commit_wptr_q] = 1'b1;
            commit_wptr_d               = commit_inc(commit_wptr_q);
        end
        if (pop) begin
            commit_vld_d[commit_rptr_q] = 1'b0;
            commit_rptr_d               = commit_inc(commit_rptr_q);
        end
        commit_cnt_d = commit_cnt_q + CCW'(commit_fire) - CCW'(pop);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            spec_vld_q    <= '0;
            spec_rptr_q   <= '0;
            spec_wptr_q   <= '0;
            spec_cnt_q    <= '0;
            commit_vld_q  <= '0;
            commit_rptr_q <= '0;
            commit_wptr_q <= '0;
            commit_cnt_q  <= '0;
        end else begin
            spec_vld_q    <= spec_vld_d;
            spec_rptr_q   <= spec_rptr_d;
            spec_wptr_q   <= spec_wptr_d;
            spec_cnt_q    <= spec_cnt_d;
            commit_vld_q  <= commit_vld_d;
            commit_rptr_q <= commit_rptr_d;
            commit_wptr_q <= commit_wptr_d;
            commit_cnt_q  <= commit_cnt_d;
`ifndef SYNTHESIS
            if (sb.commit_i && !commit_ready) begin
                $error("commit_i asserted while commit_ready_o=0; ignored");
            end
`endif
        end
    end

    // Payload storage is not reset; valid bits and counts gate every use of it.
    always_ff @(posedge clk_i) begin
        spec_mem_q   <= spec_mem_d;
        commit_mem_q <= commit_mem_d;
    end

    logic [SPEC_DEPTH-1:0]   spec_hit;
    logic [COMMIT_DEPTH-1:0] commit_hit;

    for (genvar gi = 0; gi < SPEC_DEPTH; gi++) begin : g_spec_hit
        assign spec_hit[gi] = spec_vld_q[gi] &&
                              (spec_mem_q[gi].addr[OFFSET_W-1:0] == sb.page_offset_i);
    end

    for (genvar gi = 0; gi < COMMIT_DEPTH; gi++) begin : g_commit_hit
        assign commit_hit[gi] = commit_vld_q[gi] &&
                                (commit_mem_q[gi].addr[OFFSET_W-1:0] == sb.page_offset_i);
    end

    assign head = commit_mem_q[commit_rptr_q];

    assign sb.store_ready_o        = store_ready;
    assign sb.commit_ready_o       = commit_ready;
    assign sb.mem_req_o            = mem_req;
    assign sb.mem_addr_o           = mem_req ? head.addr : '0;
    assign sb.mem_data_o           = mem_req ? head.data : '0;
    assign sb.mem_be_o             = mem_req ? head.be   : '0;
    assign sb.page_offset_match_o  = (|spec_hit) || (|commit_hit);
    assign sb.no_st_pending_o      = (commit_cnt_q == '0);
    assign sb.store_buffer_empty_o = (spec_cnt_q == '0) && (commit_cnt_q == '0);
    assign sb.spec_count_o         = spec_cnt_q;
    assign sb.commit_count_o       = commit_cnt_q;
endmodule

// File: tb/tb_cva6_store_buffer_model.sv
// Randomised and directed bench for the store buffer, checked against a queue-based
// reference model of the speculative and committed stores.
module tb_cva6_store_buffer_model;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cva6_store_buffer_model_if #(.ADDR_W(32), .DATA_W(32), .SPEC_DEPTH(4),
                                 .COMMIT_DEPTH(8), .OFFSET_W(12)) bus ();

    cva6_store_buffer_model #(.ADDR_W(32), .DATA_W(32), .SPEC_DEPTH(4),
                              .COMMIT_DEPTH(8), .OFFSET_W(12)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .sb    (bus)
    );

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  be;
    } st_t;

    st_t         spec_q[$];
    st_t         com_q[$];
    logic [31:0] pushed[$];
    logic [31:0] granted[$];
    int          tests_run    = 0;
    int          tests_failed = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic exp_match(input logic [11:0] off);
        foreach (spec_q[i]) if (spec_q[i].a[11:0] == off) return 1'b1;
        foreach (com_q[i])  if (com_q[i].a[11:0] == off)  return 1'b1;
        return 1'b0;
    endfunction

    task automatic check_outputs(input logic [11:0] off);
        logic hv;
        st_t  h;
        hv = (com_q.size() != 0);
        h  = hv ? com_q[0] : '0;
        chk("store_ready", bus.store_ready_o, spec_q.size() < 4);
        chk("commit_ready", bus.commit_ready_o, spec_q.size() != 0 && com_q.size() < 8);
        chk("mem_req", bus.mem_req_o, hv);
        chk("mem_addr", bus.mem_addr_o, h.a);
        chk("mem_data", bus.mem_data_o, h.d);
        chk("mem_be", bus.mem_be_o, h.be);
        chk("match", bus.page_offset_match_o, exp_match(off));
        chk("no_st_pending", bus.no_st_pending_o, com_q.size() == 0);
        chk("empty", bus.store_buffer_empty_o, spec_q.size() == 0 && com_q.size() == 0);
        chk("spec_count", bus.spec_count_o, spec_q.size());
        chk("commit_count", bus.commit_count_o, com_q.size());
    endtask

    task automatic idle_inputs();
        bus.store_valid_i = 1'b0;
        bus.commit_i      = 1'b0;
        bus.flush_i       = 1'b0;
        bus.mem_gnt_i     = 1'b0;
    endtask

    // One clock: drive at negedge, check before the edge, then advance the model.
    task automatic step(input logic v, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] be, input logic cm, input logic fl,
                        input logic g, input logic [11:0] off);
        logic m_sready, m_cready;
        st_t  e;
        @(negedge clk);
        m_sready = spec_q.size() < 4;
        m_cready = spec_q.size() != 0 && com_q.size() < 8;
        bus.store_valid_i = v;
        bus.store_addr_i  = a;
        bus.store_data_i  = d;
        bus.store_be_i    = be;
        bus.commit_i      = cm && m_cready;
        bus.flush_i       = fl;
        bus.mem_gnt_i     = g;
        bus.page_offset_i = off;
        #1;
        check_outputs(off);
        if (bus.mem_gnt_i && bus.mem_req_o) granted.push_back(bus.mem_addr_o);
        @(posedge clk);
        if (g && com_q.size() != 0) e = com_q.pop_front();
        if (cm && m_cready) com_q.push_back(spec_q.pop_front());
        if (v && m_sready && !fl) begin
            e.a = a; e.d = d; e.be = be;
            spec_q.push_back(e);
        end
        if (fl) spec_q.delete();
        #1;
        idle_inputs();
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_ready"}, bus.store_ready_o, 1'b1);
        chk({tag, "_cready"}, bus.commit_ready_o, 1'b0);
        chk({tag, "_req"}, bus.mem_req_o, 1'b0);
        chk({tag, "_addr"}, bus.mem_addr_o, 32'h0);
        chk({tag, "_data"}, bus.mem_data_o, 32'h0);
        chk({tag, "_be"}, bus.mem_be_o, 4'h0);
        chk({tag, "_match"}, bus.page_offset_match_o, 1'b0);
        chk({tag, "_nopend"}, bus.no_st_pending_o, 1'b1);
        chk({tag, "_empty"}, bus.store_buffer_empty_o, 1'b1);
        chk({tag, "_scnt"}, bus.spec_count_o, 3'd0);
        chk({tag, "_ccnt"}, bus.commit_count_o, 4'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        idle_inputs();
        rst = 1'b1;
        #1;
        check_reset_values("rst");
        spec_q.delete();
        com_q.delete();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && (spec_q.size() != 0 || com_q.size() != 0); i++)
            step(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b0, 1'b1, 12'h0);
        chk("drain_empty", bus.store_buffer_empty_o, 1'b1);
    endtask

    initial begin
        logic [31:0] a;
        logic        acc;
        int          p;

        idle_inputs();
        bus.store_addr_i  = '0;
        bus.store_data_i  = '0;
        bus.store_be_i    = '0;
        bus.page_offset_i = '0;
        repeat (2) @(negedge clk);
        check_reset_values("init");
        rst = 1'b0;

        // Latency: push in N, commit in N+1, request visible after N+1 edge.
        step(1'b1, 32'h1000_0040, 32'hDEAD_BEEF, 4'hF, 1'b0, 1'b0, 1'b0, 12'h040);
        chk("lat_req_early", bus.mem_req_o, 1'b0);
        step(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b0, 1'b0, 12'h040);
        chk("lat_req", bus.mem_req_o, 1'b1);
        chk("lat_addr", bus.mem_addr_o, 32'h1000_0040);
        chk("lat_data", bus.mem_data_o, 32'hDEAD_BEEF);
        step(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b1, 12'h040);
        chk("lat_empty", bus.store_buffer_empty_o, 1'b1);

        // Spec queue full: fifth push and push alongside a commit are both refused.
        for (int i = 0; i < 4; i++)
            step(1'b1, 32'h3000_0000 + 32'(i * 4), 32'(i), 4'h3, 1'b0, 1'b0, 1'b0, 12'h0);
        chk("full_ready", bus.store_ready_o, 1'b0);
        chk("full_scnt", bus.spec_count_o, 3'd4);
        step(1'b1, 32'h3000_0100, 32'h55, 4'hF, 1'b0, 1'b0, 1'b0, 12'h0);
        chk("full_5th", bus.spec_count_o, 3'd4);
        step(1'b1, 32'h3000_0200, 32'h66, 4'hF, 1'b1, 1'b0, 1'b0, 12'h0);
        chk("full_cp_scnt", bus.spec_count_o, 3'd3);
        chk("full_cp_ccnt", bus.commit_count_o, 4'd1);
        drain();

        // Commit queue fill, grant pulse, then in-order drain of 20 stores across wrap.
        pushed.delete();
        granted.delete();
        p = 0;
        for (int i = 0; i < 100 && !(com_q.size() == 8 && spec_q.size() != 0); i++) begin
            a   = 32'h2000_0000 + 32'(p * 16);
            acc = (p < 20) && (spec_q.size() < 4);
            step(p < 20, a, ~a, 4'hF, 1'b1, 1'b0, 1'b0, 12'h0);
            if (acc) begin pushed.push_back(a); p++; end
        end
        chk("cfull_cready", bus.commit_ready_o, 1'b0);
        chk("cfull_ccnt", bus.commit_count_o, 4'd8);
        step(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b1, 12'h0);
        chk("gnt_cready", bus.commit_ready_o, 1'b1);
        for (int i = 0; i < 200 && granted.size() < 20; i++) begin
            a   = 32'h2000_0000 + 32'(p * 16);
            acc = (p < 20) && (spec_q.size() < 4);
            step(p < 20, a, ~a, 4'hF, 1'b1, 1'b0, 1'b1, 12'h0);
            if (acc) begin pushed.push_back(a); p++; end
        end
        chk("order_n", granted.size(), 20);
        for (int i = 0; i < 20 && i < granted.size() && i < pushed.size(); i++)
            chk($sformatf("order_%0d", i), granted[i], pushed[i]);
        drain();

        // Flush together with commit: 3 spec + 2 committed -> 0 spec + 3 committed.
        for (int i = 0; i < 4; i++)
            step(1'b1, 32'h4000_0000 + 32'(i * 8), 32'(i), 4'h1, 1'b0, 1'b0, 1'b0, 12'h0);
        step(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b0, 1'b0, 12'h0);
        step(1'b1, 32'h4000_0040, 32'h9, 4'h1, 1'b1, 1'b0, 1'b0, 12'h0);
        chk("fl_pre_scnt", bus.spec_count_o, 3'd3);
        chk("fl_pre_ccnt", bus.commit_count_o, 4'd2);
        step(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b1, 1'b0, 12'h0);
        chk("fl_scnt", bus.spec_count_o, 3'd0);
        chk("fl_ccnt", bus.commit_count_o, 4'd3);
        chk("fl_nopend", bus.no_st_pending_o, 1'b0);
        drain();

        // Page-offset match on a speculative entry, then after it drains.
        step(1'b1, 32'h0000_2ABC, 32'h1234, 4'hF, 1'b0, 1'b0, 1'b0, 12'hABC);
        bus.page_offset_i = 12'hABC;
        #1 chk("match_hit", bus.page_offset_match_o, 1'b1);
        bus.page_offset_i = 12'hABD;
        #1 chk("match_miss", bus.page_offset_match_o, 1'b0);
        drain();
        bus.page_offset_i = 12'hABC;
        #1 chk("match_gone", bus.page_offset_match_o, 1'b0);

        // Asynchronous reset with committed stores pending.
        for (int i = 0; i < 2; i++)
            step(1'b1, 32'h5000_0000 + 32'(i * 4), 32'(i), 4'hF, 1'b0, 1'b0, 1'b0, 12'h0);
        for (int i = 0; i < 2; i++)
            step(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b0, 1'b0, 12'h0);
        chk("prerst_req", bus.mem_req_o, 1'b1);
        chk("prerst_ccnt", bus.commit_count_o, 4'd2);
        do_reset();

        // Random traffic with occasional flushes and resets.
        for (int i = 0; i < 600; i++) begin
            logic [31:0] ra, rd;
            logic [11:0] off;
            ra        = $urandom();
            rd        = $urandom();
            ra[11:0]  = 12'h100 + 12'($urandom_range(0, 7));
            off       = 12'h100 + 12'($urandom_range(0, 9));
            if ($urandom_range(0, 199) == 0) do_reset();
            else step($urandom_range(0, 1) == 1, ra, rd, 4'($urandom_range(0, 15)),
                      $urandom_range(0, 2) != 0, $urandom_range(0, 15) == 0,
                      $urandom_range(0, 2) != 0, off);
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
